// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register ids,
// the M/W pipeline register layout and its bubble value.
// No logic of its own: zero latency, no backpressure.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } mw_reg_t;

    localparam mw_reg_t MW_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        val_e: 64'd0,
        val_m: 64'd0,
        dst_e: REG_NONE,
        dst_m: REG_NONE
    };

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

    // POPQ and RET read through the old stack pointer carried in valA
    function automatic logic addr_from_val_a(input logic [3:0] icode);
        return (icode == I_POPQ) || (icode == I_RET);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle between the E/M register, the Memory stage and write-back.
// Combinational wiring only: zero latency; stall/bubble travel as plain levels.
// master: E/M side plus W controls (drives M_*, W_stall, W_bubble);
// slave : the Memory stage (drives m_valM, m_stat and the registered W_*).
interface mem_stage_if;
    logic [3:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        W_stall;
    logic        W_bubble;

    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic [3:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    modport master (
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
               W_stall, W_bubble,
        input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

    modport slave (
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
               W_stall, W_bubble,
        output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// Byte-addressed little-endian data memory, 64-bit access port.
// Read is combinational (same cycle); write commits 8 bytes at posedge clk.
// No backpressure; the caller gates writes with wr_allow (stall/status/reset).
// Ports: addr, rd_en, wr_en, wr_allow, wdata in; rdata, dmem_error out.
// Macro MEM_ALIGN_CHECK_EN: also flag accesses with addr[2:0] != 0.
module mem_stage_dmem #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              wr_allow,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              dmem_error
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    // Highest base address whose 8-byte access still fits in the array
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

    logic [7:0]       mem [MEM_BYTES];
    logic [IDX_W-1:0] base;
    logic             access;
    logic             misalign;
    logic             wr_go;

    assign base   = addr[IDX_W-1:0];
    assign access = rd_en | wr_en;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (addr[2:0] != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    // Full-width compare so wrapped addresses near 2^64 are rejected too
    assign dmem_error = access && ((addr > LAST_OK) || misalign);

    always_comb begin
        rdata = '0;
        if (rd_en && !dmem_error) begin
            for (int k = 0; k < 8; k++) begin
                rdata[8*k +: 8] = mem[base + IDX_W'(k)];
            end
        end
    end

    // All eight bytes or none: the error check covers the whole span
    assign wr_go = wr_en && wr_allow && !dmem_error;

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int k = 0; k < 8; k++) begin
                mem[base + IDX_W'(k)] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 Memory stage: data-memory access plus the M/W pipeline register.
// m_valM/m_stat are combinational (same cycle); W_* follow one cycle later.
// W_stall holds M/W and blocks stores (stall beats bubble); W_bubble loads a NOP.
// Ports: clk, rst_n (async, active low), bus (mem_stage_if.slave).
// Macro MEM_ALIGN_CHECK_EN: unaligned accesses raise ADR instead of being served.
module mem_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    logic        rd_en;
    logic        wr_en;
    logic        wr_allow;
    logic [63:0] sel_addr;
    logic [63:0] rdata;
    logic        dmem_error;
    logic        unused_cnd;

    mw_reg_t     mw_d;
    mw_reg_t     mw_q;

    assign rd_en    = is_mem_read(bus.M_icode);
    assign wr_en    = is_mem_write(bus.M_icode);
    assign sel_addr = addr_from_val_a(bus.M_icode) ? bus.M_valA : bus.M_valE;

    // A faulting or stalled instruction must not retire its store, and a
    // store caught by reset is dropped.
    assign wr_allow = (bus.M_stat == STAT_AOK) && !bus.W_stall && rst_n;

    // The condition flag only matters to the fetch stage's misprediction logic
    assign unused_cnd = bus.M_cnd;

    mem_stage_dmem #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_dmem (
        .clk        (clk),
        .addr       (sel_addr[ADDR_W-1:0]),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .wr_allow   (wr_allow),
        .wdata      (bus.M_valA),
        .rdata      (rdata),
        .dmem_error (dmem_error)
    );

    assign bus.m_valM = rdata;
    assign bus.m_stat = dmem_error ? STAT_ADR : bus.M_stat;

    always_comb begin
        mw_d = MW_BUBBLE;
        if (!bus.W_bubble) begin
            mw_d.stat  = bus.m_stat;
            mw_d.icode = bus.M_icode;
            mw_d.val_e = bus.M_valE;
            mw_d.val_m = bus.m_valM;
            mw_d.dst_e = bus.M_dstE;
            mw_d.dst_m = bus.M_dstM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw_q <= MW_BUBBLE;
        end else if (!bus.W_stall) begin
            mw_q <= mw_d;
        end
    end

    assign bus.W_stat  = mw_q.stat;
    assign bus.W_icode = mw_q.icode;
    assign bus.W_valE  = mw_q.val_e;
    assign bus.W_valM  = mw_q.val_m;
    assign bus.W_dstE  = mw_q.dst_e;
    assign bus.W_dstM  = mw_q.dst_m;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps then randomized traffic,
// compared against a byte-array reference model of the memory and M/W register.
module tb_mem_stage;
    import y86_pkg::*;

    localparam int MEM_BYTES = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (64)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: byte memory with a "known" mask (power-up is undefined)
    byte unsigned ref_mem   [MEM_BYTES];
    bit           ref_known [MEM_BYTES];

    // Expected M/W register contents
    logic [3:0]  ew_stat, ew_icode, ew_dste, ew_dstm;
    logic [63:0] ew_vale, ew_valm;
    bit          ew_valm_known;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_reads(input logic [3:0] icode);
        return icode inside {I_MRMOVQ, I_POPQ, I_RET};
    endfunction

    function automatic bit ref_writes(input logic [3:0] icode);
        return icode inside {I_RMMOVQ, I_PUSHQ, I_CALL};
    endfunction

    function automatic bit ref_error(input logic [3:0] icode, input logic [63:0] addr);
        bit bad;
        bad = (addr > 64'(MEM_BYTES - 8));
`ifdef MEM_ALIGN_CHECK_EN
        if (addr % 8 != 0) bad = 1'b1;
`endif
        return (ref_reads(icode) || ref_writes(icode)) && bad;
    endfunction

    task automatic set_ew_bubble();
        ew_stat = STAT_AOK; ew_icode = I_NOP; ew_vale = 64'd0; ew_valm = 64'd0;
        ew_dste = 4'hF; ew_dstm = 4'hF; ew_valm_known = 1'b1;
    endtask

    task automatic check_w(input string tag);
        check({tag, ".W_stat"},  bus.W_stat,  ew_stat);
        check({tag, ".W_icode"}, bus.W_icode, ew_icode);
        check({tag, ".W_valE"},  bus.W_valE,  ew_vale);
        if (ew_valm_known) check({tag, ".W_valM"}, bus.W_valM, ew_valm);
        check({tag, ".W_dstE"},  bus.W_dstE,  ew_dste);
        check({tag, ".W_dstM"},  bus.W_dstM,  ew_dstm);
    endtask

    task automatic drive(input logic [3:0] stat, input logic [3:0] icode,
                         input logic [63:0] val_e, input logic [63:0] val_a,
                         input logic [3:0] dst_e, input logic [3:0] dst_m,
                         input bit stall, input bit bubble);
        bus.M_stat = stat;   bus.M_icode = icode; bus.M_cnd = 1'b0;
        bus.M_valE = val_e;  bus.M_valA  = val_a;
        bus.M_dstE = dst_e;  bus.M_dstM  = dst_m;
        bus.W_stall = stall; bus.W_bubble = bubble;
    endtask

    // One instruction through the stage: check m_* before the edge, W_* after.
    task automatic step(input string tag, input logic [3:0] stat, input logic [3:0] icode,
                        input logic [63:0] val_e, input logic [63:0] val_a,
                        input logic [3:0] dst_e, input logic [3:0] dst_m,
                        input bit stall, input bit bubble);
        logic [63:0] addr, exp_valm;
        logic [3:0]  exp_mstat;
        bit          err, known;
        int          b;
        @(negedge clk);
        drive(stat, icode, val_e, val_a, dst_e, dst_m, stall, bubble);
        addr      = (icode == I_POPQ || icode == I_RET) ? val_a : val_e;
        err       = ref_error(icode, addr);
        exp_mstat = err ? STAT_ADR : stat;
        exp_valm  = 64'd0;
        known     = 1'b1;
        if (ref_reads(icode) && !err) begin
            for (int k = 0; k < 8; k++) begin
                b = int'(addr % MEM_BYTES) + k;
                if (!ref_known[b]) known = 1'b0;
                exp_valm = exp_valm | (64'(ref_mem[b]) << (8 * k));
            end
        end
        #1;
        check({tag, ".m_stat"}, bus.m_stat, exp_mstat);
        if (known) check({tag, ".m_valM"}, bus.m_valM, exp_valm);
        @(posedge clk);
        if (ref_writes(icode) && stat == STAT_AOK && !err && !stall) begin
            for (int k = 0; k < 8; k++) begin
                b = int'(addr % MEM_BYTES) + k;
                ref_mem[b]   = val_a[8*k +: 8];
                ref_known[b] = 1'b1;
            end
        end
        if (!stall) begin
            if (bubble) begin
                set_ew_bubble();
            end else begin
                ew_stat = exp_mstat; ew_icode = icode; ew_vale = val_e;
                ew_valm = exp_valm; ew_valm_known = known;
                ew_dste = dst_e; ew_dstm = dst_m;
            end
        end
        #1;
        check_w(tag);
    endtask

    initial begin
        logic [3:0]  ic, st, de, dm;
        logic [63:0] a, d;
        bit          sl, bb;
        int          r;

        // Reset state
        drive(STAT_AOK, I_NOP, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        set_ew_bubble();
        check_w("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load
        step("st100", STAT_AOK, I_RMMOVQ, 64'h100, 64'h1122334455667788, 4'hF, 4'hF, 0, 0);
        check("mem100", u_dut.u_dmem.mem[256], 64'h88);
        step("ld100", STAT_AOK, I_MRMOVQ, 64'h100, 64'd0, 4'hF, 4'h3, 0, 0);
        step("ld100_w", STAT_AOK, I_NOP, 64'd0, 64'd0, 4'hF, 4'hF, 0, 0);

        // PUSHQ / POPQ addressing
        step("push", STAT_AOK, I_PUSHQ, 64'h1F8, 64'hABCD, 4'h4, 4'hF, 0, 0);
        step("pop",  STAT_AOK, I_POPQ,  64'h208, 64'h1F8,  4'h4, 4'h5, 0, 0);

        // Bounds: last legal slot, one past, wrap-around
        step("st_last", STAT_AOK, I_RMMOVQ, 64'(MEM_BYTES - 8), 64'hDEADBEEF00001111, 4'hF, 4'hF, 0, 0);
        step("ld_oob",  STAT_AOK, I_MRMOVQ, 64'(MEM_BYTES - 7), 64'd0, 4'hF, 4'h2, 0, 0);
        step("st_oob",  STAT_AOK, I_RMMOVQ, 64'(MEM_BYTES - 7), 64'h5555, 4'hF, 4'hF, 0, 0);
        step("ld_last", STAT_AOK, I_MRMOVQ, 64'(MEM_BYTES - 8), 64'd0, 4'hF, 4'h2, 0, 0);
        step("ld_wrap", STAT_AOK, I_MRMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 4'hF, 4'h2, 0, 0);
        step("st_wrap", STAT_AOK, I_RMMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'h77, 4'hF, 4'hF, 0, 0);

        // Write suppression by status and by stall; stall also holds W
        step("st40",     STAT_AOK, I_RMMOVQ, 64'h40, 64'h0102030405060708, 4'hF, 4'hF, 0, 0);
        step("st40_ins", STAT_INS, I_RMMOVQ, 64'h40, 64'hFFFFFFFFFFFFFFFF, 4'hF, 4'hF, 0, 0);
        step("st40_stl", STAT_AOK, I_RMMOVQ, 64'h40, 64'h7777, 4'h1, 4'h2, 1, 0);
        step("ld40",     STAT_AOK, I_MRMOVQ, 64'h40, 64'd0, 4'hF, 4'h6, 0, 0);

        // Bubble, then stall+bubble holds
        step("bubble",  STAT_AOK, I_OPQ,    64'h1234, 64'd0, 4'h2, 4'hF, 0, 1);
        step("ld40b",   STAT_AOK, I_MRMOVQ, 64'h40, 64'd0, 4'hF, 4'h6, 0, 0);
        step("stl_bub", STAT_HLT, I_OPQ,    64'h99, 64'd0, 4'h3, 4'hF, 1, 1);

        // Asynchronous reset in the middle of a store
        @(negedge clk);
        drive(STAT_AOK, I_RMMOVQ, 64'h40, 64'h9999, 4'h2, 4'hF, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        set_ew_bubble();
        check_w("rst_async");
        @(posedge clk);
        #1;
        check_w("rst_hold");
        @(negedge clk);
        drive(STAT_AOK, I_NOP, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("ld40_rst", STAT_AOK, I_MRMOVQ, 64'h40, 64'd0, 4'hF, 4'h6, 0, 0);

        // Unaligned accesses (ADR when the alignment check is built in)
        step("st108", STAT_AOK, I_RMMOVQ, 64'h108, 64'hA0A1A2A3A4A5A6A7, 4'hF, 4'hF, 0, 0);
        step("ld103", STAT_AOK, I_MRMOVQ, 64'h103, 64'd0, 4'hF, 4'h1, 0, 0);
        step("st105", STAT_AOK, I_RMMOVQ, 64'h105, 64'hCAFEF00DBAADC0DE, 4'hF, 4'hF, 0, 0);
        step("ld100u", STAT_AOK, I_MRMOVQ, 64'h100, 64'd0, 4'hF, 4'h1, 0, 0);
        step("ld108u", STAT_AOK, I_MRMOVQ, 64'h108, 64'd0, 4'hF, 4'h1, 0, 0);

        // Fill a window with known data, then random traffic over it
        for (int i = 0; i < 64; i++) begin
            step($sformatf("fill%0d", i), STAT_AOK, I_RMMOVQ, 64'h200 + 64'(8 * i),
                 {$urandom, $urandom}, 4'hF, 4'hF, 0, 0);
        end
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: ic = I_NOP;
                1: ic = I_RMMOVQ;
                2: ic = I_MRMOVQ;
                3: ic = I_PUSHQ;
                4: ic = I_POPQ;
                5: ic = I_CALL;
                6: ic = I_RET;
                default: ic = I_OPQ;
            endcase
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = {$urandom, $urandom};
            else if (r == 1) a = 64'(MEM_BYTES) - 64'($urandom_range(0, 15));
            else             a = 64'h200 + 64'($urandom_range(0, 'h1F0));
            d  = {$urandom, $urandom};
            st = ($urandom_range(0, 9) == 0) ? STAT_INS : STAT_AOK;
            sl = ($urandom_range(0, 9) == 0);
            bb = ($urandom_range(0, 9) == 0);
            de = 4'($urandom_range(0, 15));
            dm = 4'($urandom_range(0, 15));
            if (ic == I_POPQ || ic == I_RET)
                step($sformatf("rnd%0d", i), st, ic, d, a, de, dm, sl, bb);
            else
                step($sformatf("rnd%0d", i), st, ic, a, d, de, dm, sl, bb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
